// File: rtl/key_event_queue.sv
// key_event_queue
//   Turns raw PS/2 set-2 scan-code bytes into key events and queues them
//   for a CPU.
//   The queued event format is {break, ext, code[7:0]}.
//   Prefixes handled:
//     E0        extended key
//     F0        break (key release)
//     E1 ...    Pause sequence
//   Receiver replies and error bytes are filtered out.
//
// Ports
//   Clock          sole clock, rising edge
//   Reset          synchronous, active-high
//   PS2scan_ready  one-cycle strobe qualifying PS2scan_code
//   PS2scan_code   raw scan-code byte
//   Pop            CPU read strobe, removes the head event
//   ClearOverflow  clears the sticky Overflow flag
//   EventData      head event, forced to zero while the queue is empty
//   Valid          queue non-empty
//   Count          number of queued events (0..DEPTH)
//   Overflow       sticky: an event was dropped because the queue was full
//
// Parser states
//   IDLE    | no prefix pending
//   EXT     | E0 seen
//   BRK     | F0 seen
//   EXT_BRK | E0 and F0 seen
//   PAUSE   | discarding the tail of an E1 Pause sequence
module key_event_queue #(
  parameter int DEPTH      = 8,
  parameter int PAUSE_SKIP = 7
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       PS2scan_ready,
  input  logic [7:0]                 PS2scan_code,
  input  logic                       Pop,
  input  logic                       ClearOverflow,
  output logic [9:0]                 EventData,
  output logic                       Valid,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int SKW = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t           state_q, state_d;
  logic [SKW-1:0]   skip_q, skip_d;
  logic             push;
  logic [9:0]       push_data;

  logic [9:0]       mem [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;

  logic             full, empty, do_pop, do_push, drop;

  // Bytes that are receiver replies or errors rather than key codes.
  function automatic logic is_filtered(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    push      = 1'b0;
    push_data = '0;
    if (PS2scan_ready) begin
      unique case (state_q)
        IDLE: begin
          if (PS2scan_code == 8'hE0) begin
            state_d = EXT;
          end else if (PS2scan_code == 8'hF0) begin
            state_d = BRK;
          end else if (PS2scan_code == 8'hE1) begin
            state_d = PAUSE;
            skip_d  = SKW'(PAUSE_SKIP);
          end else if (!is_filtered(PS2scan_code)) begin
            push      = 1'b1;
            push_data = {2'b00, PS2scan_code};
          end
        end
        EXT: begin
          if (PS2scan_code == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (PS2scan_code == 8'hE0) begin
            state_d = EXT;
          end else if (PS2scan_code == 8'h12) begin
            // Fake shift emitted around extended keys; never a real event.
            state_d = IDLE;
          end else begin
            push      = 1'b1;
            push_data = {2'b01, PS2scan_code};
            state_d   = IDLE;
          end
        end
        BRK: begin
          if (PS2scan_code == 8'hE0) begin
            state_d = EXT_BRK;
          end else if (PS2scan_code != 8'hF0) begin
            push      = 1'b1;
            push_data = {2'b10, PS2scan_code};
            state_d   = IDLE;
          end
        end
        EXT_BRK: begin
          if (PS2scan_code == 8'h12) begin
            state_d = IDLE;
          end else if (PS2scan_code != 8'hF0 && PS2scan_code != 8'hE0) begin
            push      = 1'b1;
            push_data = {2'b11, PS2scan_code};
            state_d   = IDLE;
          end
        end
        PAUSE: begin
          if (skip_q <= SKW'(1)) begin
            // Pause is reported as extended code 0x77 once its tail is consumed.
            skip_d    = '0;
            push      = 1'b1;
            push_data = 10'h177;
            state_d   = IDLE;
          end else begin
            skip_d = skip_q - SKW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = Pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge Clock) begin
    if (do_push) mem[tail_q] <= push_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) tail_q <= tail_q + AW'(1);
      if (do_pop)  head_q <= head_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
      // A drop coinciding with a clear wins so no loss goes unreported.
      ovf_q <= (ovf_q && !ClearOverflow) || drop;
    end
  end

  assign Valid     = !empty;
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign EventData = empty ? 10'h000 : mem[head_q];

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       PS2scan_ready;
  logic [7:0] PS2scan_code;
  logic       Pop;
  logic       ClearOverflow;
  logic [9:0] EventData;
  logic       Valid;
  logic [3:0] Count;
  logic       Overflow;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb[$];

  key_event_queue #(.DEPTH(8), .PAUSE_SKIP(7)) dut (
    .Clock(Clock), .Reset(Reset), .PS2scan_ready(PS2scan_ready),
    .PS2scan_code(PS2scan_code), .Pop(Pop), .ClearOverflow(ClearOverflow),
    .EventData(EventData), .Valid(Valid), .Count(Count), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic send(input logic [7:0] b, input logic with_pop);
    PS2scan_ready = 1'b1;
    PS2scan_code  = b;
    Pop           = with_pop;
    tick();
    PS2scan_ready = 1'b0;
    Pop           = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i], 1'b0);
  endtask

  task automatic chk_count(input string tag);
    chk({tag, "_count"}, 32'(Count), 32'(sb.size()));
    chk({tag, "_valid"}, 32'(Valid), 32'(sb.size() != 0));
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] exp;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(Valid), 32'd1);
      return;
    end
    exp = sb.pop_front();
    chk({tag, "_valid"}, 32'(Valid), 32'd1);
    chk({tag, "_data"},  32'(EventData), 32'(exp));
    Pop = 1'b1;
    tick();
    Pop = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; PS2scan_ready = 1'b0; PS2scan_code = 8'h00;
    Pop = 1'b0; ClearOverflow = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_data",  32'(EventData), 32'd0);
    chk("rst_ovf",   32'(Overflow), 32'd0);

    // make then break of the same key
    send(8'h1C, 1'b0); sb.push_back(10'h01C);
    chk_count("make_latency");
    chk("make_data", 32'(EventData), 32'h01C);
    send_seq('{8'hF0, 8'h1C}); sb.push_back(10'h21C);
    chk_count("mk_brk");
    pop_check("mk_pop0");
    pop_check("mk_pop1");
    chk("mk_empty_valid", 32'(Valid), 32'd0);
    chk("mk_empty_data",  32'(EventData), 32'd0);

    // extended make and break
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
    sb.push_back(10'h175); sb.push_back(10'h375);
    chk_count("ext");
    pop_check("ext_pop0");
    pop_check("ext_pop1");

    // pause sequence: nothing until the 7th trailing byte
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0});
    chk_count("pause_mid");
    send(8'h77, 1'b0); sb.push_back(10'h177);
    chk_count("pause_end");
    send(8'h1C, 1'b0); sb.push_back(10'h01C);
    chk_count("pause_idle");
    pop_check("pause_pop0");
    pop_check("pause_pop1");

    // fake shifts, filtered bytes, E0 after F0
    send_seq('{8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h12, 8'hAA, 8'hFA});
    chk_count("no_event");
    send_seq('{8'hF0, 8'hF0, 8'hE0, 8'h70}); sb.push_back(10'h370);
    chk_count("brk_ext");
    pop_check("brk_ext_pop");

    // overflow: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) begin
      send(8'h10 + 8'(i), 1'b0);
      if (i < 8) sb.push_back({2'b00, 8'h10 + 8'(i)});
    end
    chk("ovf_count", 32'(Count), 32'd8);
    chk("ovf_flag",  32'(Overflow), 32'd1);
    ClearOverflow = 1'b1; tick(); ClearOverflow = 1'b0;
    chk("ovf_clear", 32'(Overflow), 32'd0);

    // simultaneous push and pop while full
    chk("full_pp_head", 32'(EventData), 32'(sb[0]));
    send(8'h20, 1'b1);
    void'(sb.pop_front()); sb.push_back(10'h020);
    chk("full_pp_count", 32'(Count), 32'd8);
    chk("full_pp_ovf",   32'(Overflow), 32'd0);
    chk("full_pp_head2", 32'(EventData), 32'(sb[0]));

    // drop coinciding with clear keeps the flag
    ClearOverflow = 1'b1; send(8'h21, 1'b0); ClearOverflow = 1'b0;
    chk("clr_drop_ovf",   32'(Overflow), 32'd1);
    chk("clr_drop_count", 32'(Count), 32'd8);
    ClearOverflow = 1'b1; tick(); ClearOverflow = 1'b0;
    for (int i = 0; i < 8; i++) pop_check("drain");
    chk_count("drained");

    // pop on empty is ignored
    Pop = 1'b1; tick(); Pop = 1'b0;
    chk_count("empty_pop");
    chk("empty_pop_data", 32'(EventData), 32'd0);

    // push and pop together on empty
    send(8'h2A, 1'b1); sb.push_back(10'h02A);
    chk_count("empty_pp");
    pop_check("empty_pp_pop");

    // reset discards partial prefixes
    send(8'hE0, 1'b0); do_reset();
    send(8'h1C, 1'b0); sb.push_back(10'h01C);
    chk_count("rst_ext");
    pop_check("rst_ext_pop");
    send_seq('{8'hE1, 8'h14}); do_reset();
    send(8'h1C, 1'b0); sb.push_back(10'h01C);
    chk_count("rst_pause");
    chk("rst_pause_data", 32'(EventData), 32'h01C);

    // reset wins over a byte, pop and clear in the same cycle
    send(8'h33, 1'b0); sb.push_back(10'h033);
    Reset = 1'b1; PS2scan_ready = 1'b1; PS2scan_code = 8'h1C; Pop = 1'b1; ClearOverflow = 1'b1;
    tick();
    Reset = 1'b0; PS2scan_ready = 1'b0; Pop = 1'b0; ClearOverflow = 1'b0;
    sb.delete();
    chk_count("rst_prio");
    chk("rst_prio_data", 32'(EventData), 32'd0);
    chk("rst_prio_ovf",  32'(Overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO entries; SHALL be a power of two, 2 to 64.
REQ-002 Parameter PAUSE_SKIP, default 7, bytes discarded after an E1 prefix.
REQ-003 Clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 PS2scan_ready  input  1  one-cycle strobe marking PS2scan_code valid.
REQ-006 PS2scan_code  input  8  raw scan-code byte from the PS/2 receiver.
REQ-007 Pop  input  1  CPU read strobe; removes the head event.
REQ-008 ClearOverflow  input  1  clears Overflow.
REQ-009 EventData  output  10  head event {break, ext, code[7:0]}; zero when Valid=0.
REQ-010 Valid  output  1  FIFO non-empty.
REQ-011 Count  output  clog2(DEPTH)+1  number of queued events.
REQ-012 Overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 The parser FSM SHALL have states IDLE, EXT, BRK, EXT_BRK and PAUSE, and SHALL advance only on cycles with PS2scan_ready=1.
REQ-014 In IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter=PAUSE_SKIP; 00, AA, EE, FA, FC, FD, FE, FF -> dropped, stay in IDLE; any other byte -> push {0,0,byte}, stay in IDLE.
REQ-015 In EXT: F0 -> EXT_BRK; E0 -> stay in EXT; 12 (fake shift) -> IDLE with no push; any other byte -> push {0,1,byte}, go to IDLE.
REQ-016 In BRK: any byte other than F0/E0 -> push {1,0,byte}, go to IDLE; F0 -> stay in BRK; E0 -> EXT_BRK.
REQ-017 In EXT_BRK: 12 -> IDLE with no push; F0/E0 -> stay in EXT_BRK; any other byte -> push {1,1,byte}, go to IDLE.
REQ-018 In PAUSE: each byte decrements the skip counter; on the byte that brings it to 0, push {0,1,0x77} and go to IDLE.
REQ-019 A pushed event SHALL be visible at the FIFO output (Valid, Count, EventData) on the cycle after the clock edge that samples the final byte, i.e. one-cycle latency.
REQ-020 The FIFO SHALL be a circular buffer with head/tail pointers that wrap modulo DEPTH; Count SHALL never exceed DEPTH.
REQ-021 EventData SHALL always present the oldest entry; Pop with Valid=1 SHALL advance head at the clock edge.
REQ-022 Pop with Valid=0 SHALL be ignored, with no pointer change and no error.
REQ-023 Push and Pop in the same cycle with 0 < Count < DEPTH: both SHALL succeed, and Count is unchanged.
REQ-024 Push and Pop in the same cycle with Count=DEPTH: both SHALL succeed, Count stays DEPTH, and Overflow is not set.
REQ-025 Push and Pop in the same cycle with Count=0: push only, and Count becomes 1.
REQ-026 Push with Count=DEPTH and no Pop: the event SHALL be dropped, the FIFO is unchanged, and Overflow is set to 1.
REQ-027 Overflow SHALL remain set until ClearOverflow=1; if ClearOverflow and a new drop coincide, Overflow SHALL stay 1.
REQ-028 The parser state SHALL be independent of FIFO fullness; dropped events still advance the FSM.

Reset
REQ-029 Reset=1 at a clock edge SHALL set the FSM to IDLE, skip counter to 0, head/tail/Count to 0, Overflow to 0, Valid to 0 and EventData to 0.
REQ-030 Reset SHALL take priority over PS2scan_ready, Pop and ClearOverflow in the same cycle.
REQ-031 Reset asserted mid-sequence (e.g. after E0, or inside PAUSE) SHALL discard the partial prefix; the next byte is parsed from IDLE.
REQ-032 FIFO storage contents need not be cleared, but SHALL never be observable while Valid=0.

Verification
REQ-033 Bytes 1C, F0, 1C -> events {0,0,1C} then {1,0,1C}; Count=2; Pop twice -> Valid=0, EventData=0.
REQ-034 Bytes E0, 75, E0, F0, 75 -> events 0x175 then 0x375.
REQ-035 Bytes E1,14,77,E1,F0,14,F0,77 -> exactly one event 0x177; FSM back in IDLE afterwards.
REQ-036 Push 9 make codes with DEPTH=8 and no Pop -> Count=8, first 8 retained, Overflow=1; ClearOverflow -> Overflow=0.
REQ-037 With Count=8, push and Pop in the same cycle -> Count=8, Overflow=0, oldest entry replaced in order; with Count=0, Pop alone -> no change.
REQ-038 Send E0 then assert Reset, then send 1C -> single event 0x01C; bytes AA and FA alone -> no events.
